// File: rtl/bp_me_pkg.sv
// Shared types and default widths for the memory-engine command arbiter.
package bp_me_pkg;

  localparam int mem_header_width_lp  = 64;
  localparam int bedrock_data_width_p = 64;

  typedef enum logic [0:0] {
    e_arb_idle = 1'b0,
    e_arb_lock = 1'b1
  } bp_me_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin selector; the priority pointer only moves when a burst completes.
module bsg_arb_round_robin #(
  parameter int num_req_p    = 2,
  parameter int ptr_width_lp = $clog2(num_req_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [num_req_p-1:0]    reqs_i,
  output logic [num_req_p-1:0]    grants_o,
  input  logic                    update_v_i,
  input  logic [ptr_width_lp-1:0] update_idx_i
);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;
  logic [ptr_width_lp-1:0] idx;
  logic                    found;

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    grants_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = ptr_width_lp'((int'(ptr_q) + i) % num_req_p);
      if (!found && reqs_i[idx]) begin
        grants_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_v_i) begin
      ptr_d = (update_idx_i == ptr_width_lp'(num_req_p - 1)) ? '0
                                                              : update_idx_i + ptr_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_mux_one_hot.sv
// AND-OR one-hot mux; an all-zero select yields an all-zero output.
module bsg_mux_one_hot #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) begin
      data_o = data_o | (data_i[i*width_p +: width_p] & {width_p{sel_one_hot_i[i]}});
    end
  end

endmodule

// File: rtl/bp_me_mem_cmd_burst_arb.sv
// Burst-locking arbiter: several requesters share one CCE-MEM command channel.
// Handshake: a beat transfers when mem_cmd_v_o && mem_cmd_ready_and_i; once offered, a beat is held until taken.
module bp_me_mem_cmd_burst_arb
  import bp_me_pkg::*;
#(
  parameter int num_req_p      = 2,
  parameter int header_width_p = mem_header_width_lp,
  parameter int data_width_p   = bedrock_data_width_p,
  parameter int max_beats_p    = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p*header_width_p-1:0] req_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p-1:0]                req_last_i,
  output logic [num_req_p-1:0]                req_ready_and_o,
  output logic [header_width_p-1:0]           mem_cmd_header_o,
  output logic [data_width_p-1:0]             mem_cmd_data_o,
  output logic                                mem_cmd_v_o,
  output logic                                mem_cmd_last_o,
  input  logic                                mem_cmd_ready_and_i,
  output logic [num_req_p-1:0]                grant_o,
  output logic                                err_o
);

  localparam int ptr_width_lp  = $clog2(num_req_p);
  localparam int cnt_width_lp  = $clog2(max_beats_p + 1);
  localparam int beat_width_lp = header_width_p + data_width_p + 2;

  bp_me_arb_state_e        state_q, state_d;
  logic [num_req_p-1:0]    lock_grant_q, lock_grant_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [num_req_p-1:0]               rr_grant, grant;
  logic [ptr_width_lp-1:0]            grant_idx;
  logic                               ptr_update;
  logic                               hs;
  logic [num_req_p*beat_width_lp-1:0] mux_in;
  logic [beat_width_lp-1:0]           mux_out;

  bsg_arb_round_robin #(.num_req_p(num_req_p)) rr (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .reqs_i      (req_v_i),
    .grants_o    (rr_grant),
    .update_v_i  (ptr_update),
    .update_idx_i(grant_idx)
  );

  assign grant = (state_q == e_arb_idle) ? rr_grant : lock_grant_q;

  always_comb begin
    mux_in = '0;
    for (int i = 0; i < num_req_p; i++) begin
      mux_in[i*beat_width_lp +: beat_width_lp] = {req_header_i[i*header_width_p +: header_width_p],
                                                  req_data_i[i*data_width_p +: data_width_p],
                                                  req_v_i[i], req_last_i[i]};
    end
  end

  bsg_mux_one_hot #(.width_p(beat_width_lp), .els_p(num_req_p)) out_mux (
    .data_i       (mux_in),
    .sel_one_hot_i(grant),
    .data_o       (mux_out)
  );

  assign {mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o, mem_cmd_last_o} = mux_out;
  assign req_ready_and_o = grant & {num_req_p{mem_cmd_ready_and_i}};
  assign grant_o         = grant;
  assign err_o           = err_q;
  assign hs              = mem_cmd_v_o & mem_cmd_ready_and_i;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant[i]) grant_idx = ptr_width_lp'(i);
    end
  end

  // A stalled first beat still locks, so an offered beat can never be reassigned.
  always_comb begin
    state_d      = state_q;
    lock_grant_d = lock_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ptr_update   = 1'b0;
    if (hs && !mem_cmd_last_o && (cnt_q == cnt_width_lp'(max_beats_p - 1))) err_d = 1'b1;
    case (state_q)
      e_arb_idle: begin
        if (|grant) begin
          if (hs && mem_cmd_last_o) begin
            ptr_update = 1'b1;
          end else begin
            state_d      = e_arb_lock;
            lock_grant_d = grant;
            cnt_d        = hs ? cnt_width_lp'(1) : '0;
          end
        end
      end
      e_arb_lock: begin
        if (hs && mem_cmd_last_o) begin
          state_d      = e_arb_idle;
          lock_grant_d = '0;
          cnt_d        = '0;
          ptr_update   = 1'b1;
        end else if (hs && (cnt_q != cnt_width_lp'(max_beats_p))) begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      default: state_d = e_arb_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_arb_idle;
      lock_grant_q <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_grant_q <= lock_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_burst_arb.sv
// Bench for the burst arbiter: scenario tasks plus a beat scoreboard on the output channel.
module tb_bp_me_mem_cmd_burst_arb;

  localparam int NR = 2;
  localparam int HW = 16;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int BW = HW + DW + 1;

  logic            clk;
  logic            rst_n;
  logic [NR*HW-1:0] req_header;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_v;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    ready_and;
  logic [HW-1:0]    mem_header;
  logic [DW-1:0]    mem_data;
  logic             mem_v;
  logic             mem_last;
  logic             mem_ready;
  logic [NR-1:0]    grant;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp_b;

  bp_me_mem_cmd_burst_arb #(
    .num_req_p(NR), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .req_header_i       (req_header),
    .req_data_i         (req_data),
    .req_v_i            (req_v),
    .req_last_i         (req_last),
    .req_ready_and_o    (ready_and),
    .mem_cmd_header_o   (mem_header),
    .mem_cmd_data_o     (mem_data),
    .mem_cmd_v_o        (mem_v),
    .mem_cmd_last_o     (mem_last),
    .mem_cmd_ready_and_i(mem_ready),
    .grant_o            (grant),
    .err_o              (err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  // Scoreboard: every transferred beat must match the oldest expected beat
  always @(negedge clk) begin
    if (rst_n && mem_v && mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got hdr=%h data=%h last=%b, required no beat", mem_header, mem_data, mem_last);
      end else begin
        exp_b = exp_q.pop_front();
        if ({mem_header, mem_data, mem_last} !== exp_b) begin
          errors++;
          $display("FAIL sb_beat: got %h, required %h", {mem_header, mem_data, mem_last}, exp_b);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req_v = '0; req_last = '0; req_header = '0; req_data = '0;
  endtask

  task automatic drive_req(input int r, input logic v, input logic last,
                           input logic [HW-1:0] h, input logic [DW-1:0] d);
    req_v[r] = v;
    req_last[r] = last;
    req_header[r*HW +: HW] = h;
    req_data[r*DW +: DW] = d;
  endtask

  task automatic push_exp(input logic [HW-1:0] h, input logic [DW-1:0] d, input logic last);
    exp_q.push_back({h, d, last});
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", grant); end
    checks++; if (mem_v !== 1'b0) begin errors++; $display("FAIL reset_v: got %b, required 0", mem_v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++; if (mem_header !== '0) begin errors++; $display("FAIL reset_hdr: got %h, required 0", mem_header); end
    drive_req(0, 1'b1, 1'b1, 16'hABCD, 32'h1234_5678);
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_idle_grant: got %b, required 01", grant); end
    checks++; if (mem_header !== 16'hABCD) begin errors++; $display("FAIL reset_idle_hdr: got %h, required abcd", mem_header); end
    checks++; if (ready_and !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, required 00", ready_and); end
    idle_all();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    mem_ready = 1'b1;
    drive_req(0, 1'b0, 1'b1, 16'h1111, 32'h2222_3333);
    drive_req(1, 1'b0, 1'b1, 16'h4444, 32'h5555_6666);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL idle_grant: got %b, required 00", grant); end
    checks++; if ({mem_header, mem_data, mem_v, mem_last} !== '0) begin errors++; $display("FAIL idle_outputs: got %h, required 0", {mem_header, mem_data, mem_v, mem_last}); end
    checks++; if (ready_and !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b, required 00", ready_and); end
    tick();
    idle_all();
  endtask

  task automatic test_contention();
    logic [DW-1:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    mem_ready = 1'b1;
    drive_req(0, 1'b1, 1'b1, 16'h0A00, d0);
    drive_req(1, 1'b1, 1'b1, 16'h0B00, d1);
    push_exp(16'h0A00, d0, 1'b1);
    push_exp(16'h0B00, d1, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_grant0: got %b, required 01", grant); end
    checks++; if (ready_and !== 2'b01) begin errors++; $display("FAIL cont_ready0: got %b, required 01", ready_and); end
    tick();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL cont_grant1: got %b, required 10", grant); end
    checks++; if (ready_and !== 2'b10) begin errors++; $display("FAIL cont_ready1: got %b, required 10", ready_and); end
    tick();
    idle_all();
  endtask

  task automatic test_burst_lock();
    logic [DW-1:0] d, d1;
    d1 = $urandom;
    mem_ready = 1'b1;
    drive_req(1, 1'b1, 1'b1, 16'h2000, d1);
    for (int b = 0; b < 4; b++) begin
      d = $urandom;
      drive_req(0, 1'b1, (b == 3), 16'h1000 | 16'(b), d);
      push_exp(16'h1000 | 16'(b), d, (b == 3));
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL lock_grant beat %0d: got %b, required 01", b, grant); end
      checks++; if (ready_and[1] !== 1'b0) begin errors++; $display("FAIL lock_ready1 beat %0d: got %b, required 0", b, ready_and[1]); end
      tick();
    end
    drive_req(0, 1'b0, 1'b0, '0, '0);
    push_exp(16'h2000, d1, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lock_next_grant: got %b, required 10", grant); end
    tick();
    idle_all();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] da, db;
    da = $urandom; db = $urandom;
    mem_ready = 1'b0;
    drive_req(0, 1'b1, 1'b1, 16'h3AAA, da);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive_req(1, 1'b1, 1'b1, 16'h3BBB, db);
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL bp_grant cycle %0d: got %b, required 01", c, grant); end
      checks++; if (mem_header !== 16'h3AAA) begin errors++; $display("FAIL bp_hdr cycle %0d: got %h, required 3aaa", c, mem_header); end
      tick();
    end
    mem_ready = 1'b1;
    push_exp(16'h3AAA, da, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL bp_release_grant: got %b, required 01", grant); end
    tick();
    drive_req(0, 1'b0, 1'b0, '0, '0);
    push_exp(16'h3BBB, db, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b, required 10", grant); end
    tick();
    idle_all();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] d;
    mem_ready = 1'b1;
    for (int b = 0; b < MB; b++) begin
      d = $urandom;
      drive_req(0, 1'b1, 1'b0, 16'h4000 | 16'(b), d);
      push_exp(16'h4000 | 16'(b), d, 1'b0);
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_early beat %0d: got %b, required 0", b, err); end
      tick();
    end
    d = $urandom;
    drive_req(0, 1'b1, 1'b1, 16'h40FF, d);
    push_exp(16'h40FF, d, 1'b1);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, required 1", err); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ovr_grant: got %b, required 01", grant); end
    tick();
    idle_all();
    @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", err); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ovr_end_grant: got %b, required 00", grant); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    mem_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      d = $urandom;
      drive_req(0, 1'b1, 1'b0, 16'h5000 | 16'(b), d);
      push_exp(16'h5000 | 16'(b), d, 1'b0);
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL mrst_grant beat %0d: got %b, required 01", b, grant); end
      tick();
    end
    rst_n = 1'b0;
    idle_all();
    mem_ready = 1'b0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mrst_grant_zero: got %b, required 00", grant); end
    checks++; if (mem_v !== 1'b0) begin errors++; $display("FAIL mrst_v: got %b, required 0", mem_v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b, required 0", err); end
    drive_req(0, 1'b1, 1'b1, 16'h5A00, 32'h0);
    drive_req(1, 1'b1, 1'b1, 16'h5B00, 32'h0);
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL mrst_ptr: got %b, required 01", grant); end
    idle_all();
    tick();
    rst_n = 1'b1;
    d = $urandom;
    mem_ready = 1'b1;
    drive_req(1, 1'b1, 1'b1, 16'h5B01, d);
    push_exp(16'h5B01, d, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL mrst_new_grant: got %b, required 10", grant); end
    checks++; if (ready_and !== 2'b10) begin errors++; $display("FAIL mrst_new_ready: got %b, required 10", ready_and); end
    tick();
    idle_all();
  endtask

  task automatic test_back_to_back();
    int r, len;
    logic done;
    logic [HW-1:0] h;
    logic [DW-1:0] d;
    logic [NR-1:0] exp_g;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 1);
      len = $urandom_range(1, 4);
      exp_g = NR'(1 << r);
      for (int b = 0; b < len; b++) begin
        h = 16'h6000 + 16'(r * 256 + n * 8 + b);
        d = $urandom;
        idle_all();
        drive_req(r, 1'b1, (b == len - 1), h, d);
        push_exp(h, d, (b == len - 1));
        done = 1'b0;
        for (int t = 0; t < 16 && !done; t++) begin
          mem_ready = (t >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
          @(negedge clk);
          checks++;
          if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant burst %0d beat %0d: got %b, required %b", n, b, grant, exp_g); end
          done = mem_ready;
          tick();
        end
        if (!done) begin errors++; $display("FAIL b2b_timeout burst %0d beat %0d: got no handshake, required one", n, b); end
      end
    end
    idle_all();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b, required 0", err); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_contention();
    test_burst_lock();
    test_backpressure();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d beats left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
